// File: rtl/led_pkg.sv
// Shared mode codes and initial LED patterns for the LED demo controller.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_RUN   = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    localparam logic [3:0] PAT_OFF   = 4'b0000;
    localparam logic [3:0] PAT_ON    = 4'b1111;
    localparam logic [3:0] PAT_RUN   = 4'b0001;
    localparam logic [3:0] PAT_BLINK = 4'b1111;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:   next_mode = MODE_ON;
            MODE_ON:    next_mode = MODE_RUN;
            MODE_RUN:   next_mode = MODE_BLINK;
            default:    next_mode = MODE_OFF;
        endcase
    endfunction

    function automatic logic [3:0] init_pattern(input mode_t m);
        case (m)
            MODE_OFF:   init_pattern = PAT_OFF;
            MODE_ON:    init_pattern = PAT_ON;
            MODE_RUN:   init_pattern = PAT_RUN;
            default:    init_pattern = PAT_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key synchroniser, optional debounce filter (KEY_DEBOUNCE_EN) and
// falling-edge detect producing a one-cycle press pulse.
module key_debounce
`ifdef KEY_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic press
);

    logic sync_q1;
    logic sync_q2;
    logic deb_level;
    logic deb_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    logic [15:0] deb_cnt;

    // Level flips on the cycle the disagreement count would reach the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b1;
        end else if (sync_q2 != deb_level) begin
            if (deb_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                deb_level <= sync_q2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 16'd1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end
`else
    always_comb deb_level = sync_q2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_prev <= 1'b1;
        end else begin
            deb_prev <= deb_level;
        end
    end

    // Combinational so the mode register updates on the very next edge.
    always_comb press = deb_prev & ~deb_level;

endmodule

// File: rtl/led_mode_ctrl.sv
// Key-driven 4-mode LED sequencer: OFF -> ON -> RUN -> BLINK -> OFF.
// Debounce filter is present only when KEY_DEBOUNCE_EN is defined.
module led_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STEP_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic [3:0] led,
    output logic [1:0] mode
);

    import led_pkg::*;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..65535");
    end
    if (STEP_CYCLES < 2 || STEP_CYCLES > 65535) begin : g_bad_step
        $error("STEP_CYCLES out of range 2..65535");
    end

    logic        press;
    logic        tick;
    mode_t       mode_q;
    logic [15:0] step_cnt;

    key_debounce
`ifdef KEY_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    )
`endif
    u_key (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in),
        .press  (press)
    );

    always_comb tick = (step_cnt == 16'(STEP_CYCLES - 1));

    // A press outranks a coincident tick: the tick is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            led      <= PAT_OFF;
            step_cnt <= '0;
        end else if (press) begin
            mode_q   <= next_mode(mode_q);
            led      <= init_pattern(next_mode(mode_q));
            step_cnt <= '0;
        end else begin
            step_cnt <= tick ? '0 : step_cnt + 16'd1;
            if (tick) begin
                case (mode_q)
                    MODE_RUN:   led <= {led[2:0], led[3]};
                    MODE_BLINK: led <= ~led;
                    default:    led <= led;
                endcase
            end
        end
    end

    always_comb mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed, table-driven bench for led_mode_ctrl; adapts expected latencies
// to whether KEY_DEBOUNCE_EN is defined.
module tb_led_mode_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned S = 8;
`ifdef KEY_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif
    // Steps from driving key low (just after an edge) to the edge that updates mode.
    localparam int UPD = DEB_EN ? 3 + int'(D) : 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b1;
    logic [3:0] led;
    logic [1:0] mode;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       r;
        logic       k;
        int         n;
        logic [1:0] m;
        logic [3:0] l;
    } vec_t;

    vec_t vecs[$];

    always #10 clk = ~clk;

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .STEP_CYCLES(S)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in),
        .led    (led),
        .mode   (mode)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [1:0] m, input logic [3:0] l);
        total++;
        if (mode !== m || led !== l) begin
            bad++;
            $display("FAIL %s: got mode=%0d led=%b, expected mode=%0d led=%b",
                     name, mode, led, m, l);
        end
    endtask

    task automatic press_key();
        key_in = 1'b0;
        step(UPD);
        key_in = 1'b1;
        step(10);
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic k,
                                input int n, input logic [1:0] m, input logic [3:0] l);
        vec_t v;
        v.name = name; v.r = r; v.k = k; v.n = n; v.m = m; v.l = l;
        return v;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] gm;
        logic [3:0] gl;
        gm = DEB_EN ? 2'd0 : 2'd1;
        gl = DEB_EN ? 4'b0000 : 4'b1111;

        vecs.push_back(mk("reset",          1, 1, 2,       0, 4'b0000));
        vecs.push_back(mk("idle_hold",      0, 1, 100,     0, 4'b0000));
        vecs.push_back(mk("press1_early",   0, 0, UPD - 1, 0, 4'b0000));
        vecs.push_back(mk("press1_on",      0, 0, 1,       1, 4'b1111));
        vecs.push_back(mk("press1_hold",    0, 0, 10 - UPD,1, 4'b1111));
        vecs.push_back(mk("release1",       0, 1, 20,      1, 4'b1111));
        vecs.push_back(mk("press2_early",   0, 0, UPD - 1, 1, 4'b1111));
        vecs.push_back(mk("run_entry",      0, 0, 1,       2, 4'b0001));
        vecs.push_back(mk("run_pre_tick",   0, 0, 7,       2, 4'b0001));
        vecs.push_back(mk("run_0010",       0, 0, 1,       2, 4'b0010));
        vecs.push_back(mk("run_pre_tick2",  0, 1, 7,       2, 4'b0010));
        vecs.push_back(mk("run_0100",       0, 1, 1,       2, 4'b0100));
        vecs.push_back(mk("run_1000",       0, 1, 8,       2, 4'b1000));
        vecs.push_back(mk("run_wrap_0001",  0, 1, 8,       2, 4'b0001));
        vecs.push_back(mk("press3_early",   0, 0, UPD - 1, 2, 4'b0001));
        vecs.push_back(mk("blink_entry",    0, 0, 1,       3, 4'b1111));
        vecs.push_back(mk("blink_pre",      0, 0, 7,       3, 4'b1111));
        vecs.push_back(mk("blink_0000",     0, 1, 1,       3, 4'b0000));
        vecs.push_back(mk("blink_1111",     0, 1, 8,       3, 4'b1111));
        vecs.push_back(mk("blink_0000b",    0, 1, 8,       3, 4'b0000));
        vecs.push_back(mk("press4_early",   0, 0, UPD - 1, 3, 4'b0000));
        vecs.push_back(mk("wrap_off",       0, 0, 1,       0, 4'b0000));
        vecs.push_back(mk("off_hold",       0, 1, 20,      0, 4'b0000));
        vecs.push_back(mk("glitch_low",     0, 0, 2,       0, 4'b0000));
        vecs.push_back(mk("glitch_edge2",   0, 1, 1,       gm, gl));
        vecs.push_back(mk("glitch_settle",  0, 1, 20,      gm, gl));

        foreach (vecs[i]) begin
            rst    = vecs[i].r;
            key_in = vecs[i].k;
            step(vecs[i].n);
            check(vecs[i].name, vecs[i].m, vecs[i].l);
        end

        // Press timed to land on a RUN tick.
        rst = 1'b1; key_in = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        check("reset2", 2'd0, 4'b0000);
        press_key();
        press_key();
        check("coll_run", 2'd2, 4'b0010);
        step(14 - UPD);
        key_in = 1'b0;
        step(UPD - 1);
        check("coll_before", 2'd2, 4'b0100);
        step(1);
        check("coll_blink", 2'd3, 4'b1111);
        key_in = 1'b1;
        step(7);
        check("coll_hold", 2'd3, 4'b1111);
        step(1);
        check("coll_toggle", 2'd3, 4'b0000);

        // Reset pulse in the middle of RUN.
        press_key();
        press_key();
        press_key();
        check("mid_run", 2'd2, 4'b0010);
        step(3);
        rst = 1'b1;
        step(1);
        check("mid_rst", 2'd0, 4'b0000);
        rst = 1'b0;
        step(20);
        check("mid_rst_hold", 2'd0, 4'b0000);

        // Key held low across reset: exactly one advance afterwards.
        press_key();
        check("pre_hold_on", 2'd1, 4'b1111);
        key_in = 1'b0;
        rst    = 1'b1;
        step(3);
        check("held_rst", 2'd0, 4'b0000);
        rst = 1'b0;
        step(UPD - 1);
        check("held_early", 2'd0, 4'b0000);
        step(1);
        check("held_adv", 2'd1, 4'b1111);
        step(30);
        check("held_once", 2'd1, 4'b1111);
        key_in = 1'b1;
        step(15);

        // Pulse width boundary: D-1 cycles ignored, D cycles accepted.
        key_in = 1'b0;
        step(int'(D) - 1);
        key_in = 1'b1;
        step(15);
        check("pulse_dm1", DEB_EN ? 2'd1 : 2'd2, DEB_EN ? 4'b1111 : 4'b0010);
        key_in = 1'b0;
        step(int'(D));
        key_in = 1'b1;
        step(15);
        check("pulse_d", DEB_EN ? 2'd2 : 2'd3, DEB_EN ? 4'b0010 : 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Key-driven LED sequencing controller for the LED demo design: sits between the raw push-button input `key_in` and the 4-bit `led` output inside `led_top`. It synchronises and debounces the active-low key and advances a 4-mode state machine on each press. A prescaled step tick animates the running-light and blink patterns. All outputs are registered.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles the synchronised key must disagree with the debounced state before the debounced state flips; legal range 1..65535.
- `STEP_CYCLES`, default 8: clock cycles per pattern step tick; legal range 2..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key_in`  in  1  raw push-button, active-low (idle 1), asynchronous to `clk`.
- `led`  out  4  LED drive, 1 = lit; reset value 4'b0000.
- `mode`  out  2  current mode code; reset value 2'd0.

## Operation
- Input path: 2-flop synchroniser (both flops reset to 1), then debounce filter, then falling-edge detect on the debounced level, producing a 1-cycle `press` pulse. Release generates no event.
- Debounce: the counter increments each cycle the synchronised key differs from the debounced level and clears on any cycle they agree. When it would reach `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears. Pulses shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- Mode FSM, advanced by `press`: OFF(0) -> ON(1) -> RUN(2) -> BLINK(3) -> OFF(0); wraps from BLINK to OFF.
- On a mode change, `led` loads the mode's initial pattern on the same edge and the step counter clears. Initial patterns: OFF 0000, ON 1111, RUN 0001, BLINK 1111.
- Step counter: counts 0..`STEP_CYCLES`-1 and wraps. `tick` is asserted in the cycle where count == `STEP_CYCLES`-1.
- On `tick`:
  - RUN: rotate `led` left by 1 (1000 -> 0001).
  - BLINK: invert `led`.
  - OFF and ON: no change.
- `press` and `tick` in the same cycle: `press` wins; the mode advances, the initial pattern loads, the counter clears and the tick is discarded.
- Key held low through reset: the synchroniser restarts at 1, so exactly one press is registered after reset.

## Timing
- Edge 0 is the first rising edge that samples `key_in` low.
  - Debounced level goes low after edge 1+`DEBOUNCE_CYCLES`.
  - `press` is high in the following cycle.
  - `mode` and `led` update at edge 2+`DEBOUNCE_CYCLES` (edge 6 at default).
- With `KEY_DEBOUNCE_EN` undefined, `mode` and `led` update at edge 2.
- In RUN or BLINK with no presses, `led` changes once every `STEP_CYCLES` cycles. The first change occurs `STEP_CYCLES` cycles after the mode-entry edge.
- `rst` sampled high at an edge:
  - the next cycle shows `mode`=0 and `led`=0000;
  - all counters are 0 and the synchroniser and debounced level are 1;
  - any in-progress debounce is abandoned.

## Configuration
- `KEY_DEBOUNCE_EN` defined: the debounce filter is instantiated as described above.
- `KEY_DEBOUNCE_EN` undefined:
  - the debounced level is the synchroniser output directly;
  - `DEBOUNCE_CYCLES` is ignored and no counter is generated;
  - every synchronised falling edge, including glitches, advances the mode.

## Structure
- Shared package `led_pkg` holds:
  - mode codes `MODE_OFF`/`MODE_ON`/`MODE_RUN`/`MODE_BLINK` as a 2-bit typedef;
  - initial-pattern constants `PAT_OFF`/`PAT_ON`/`PAT_RUN`/`PAT_BLINK`.
- Sub-module `key_debounce`: synchroniser, the `KEY_DEBOUNCE_EN`-guarded filter and fall-edge detect. Outputs the `press` pulse.
- FSM, step counter and LED register remain in `led_mode_ctrl`.

## Test plan
Defaults `DEBOUNCE_CYCLES`=4, `STEP_CYCLES`=8, 20 ns clock.
1. Reset: `rst`=1 for 2 cycles with `key_in`=1 -> `led`=0000 and `mode`=0; they hold with no key activity for 100 cycles.
2. Clean press: `key_in` low for 10 cycles from edge 0, then high -> `mode`=1 and `led`=1111 at edge 6; no change on release.
3. Glitch: `key_in` low for 2 cycles:
   - with `KEY_DEBOUNCE_EN`, `mode` is unchanged;
   - without it, `mode` advances 0 -> 1 at edge 2.
4. RUN sequence: two clean presses reach `mode`=2 with `led`=0001. Then every 8 cycles: 0010, 0100, 1000, 0001 (wrap checked).
5. BLINK and wrap:
   - third press gives `mode`=3; `led` toggles 1111/0000 every 8 cycles;
   - fourth press gives `mode`=0 and `led`=0000.
6. Collision and mid-run reset:
   - press aligned with a RUN tick -> BLINK with `led`=1111; next toggle exactly 8 cycles later;
   - `rst` pulse mid-RUN -> `mode`=0 and `led`=0000 next cycle;
   - key held low across reset -> exactly one advance.
